// File: rtl/lp_pkg.sv
// lp_pkg
// Shared definitions for the low-power demonstration top.
//   pwr_state_t   : power-controller states (always-on domain)
//   PWR_UP_CYCLES : cycles spent in UP while the core supply ramps
//   ISO_CLAMP     : value driven on op1 while the core is isolated
package lp_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_UP      = 3'd1,
    ST_RESTORE = 3'd2,
    ST_ON      = 3'd3,
    ST_SAVE    = 3'd4,
    ST_DOWN    = 3'd5
  } pwr_state_t;

  localparam int   PWR_UP_CYCLES = 2;
  localparam logic ISO_CLAMP     = 1'b0;

endpackage : lp_pkg

// File: rtl/lp_core.sv
// lp_core
// Switchable-domain core (VDD_0d8 / VSS). Registers f = (in1 & in2) ^ in3.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   sw_en          : power switch enable; core_q is forced to 0 while low
//   restore        : load core_q from the retention value ret_d
//   ret_d          : retained value from the always-on domain
//   in1, in2, in3  : data inputs
//   core_q         : registered core result (unisolated)
module lp_core
  import lp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sw_en,
  input  logic restore,
  input  logic ret_d,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic core_q
);

  logic f;

  assign f = (in1 & in2) ^ in3;

  // With the switch open the register has no supply; model that as 0.
  // In UP and SAVE the register may track f, but that value is never seen:
  // op1 is isolated there, RESTORE overwrites it, and the retention
  // register has already sampled the last ON value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_q <= 1'b0;
    end else if (!sw_en) begin
      core_q <= 1'b0;
    end else if (restore) begin
      core_q <= ret_d;
    end else begin
      core_q <= f;
    end
  end

endmodule : lp_core

// File: rtl/lp_design_top.sv
// lp_design_top
// Low-power demonstration top. The always-on domain (VDD_1d0) holds the
// power-controller FSM, the retention register and the output isolation;
// lp_core lives in the switchable domain (VDD_0d8).
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   top_pwr_sw     : core power request (1 = on, 0 = off), synchronous
//   in1, in2, in3  : core data inputs
//   op1            : isolated, registered core result
module lp_design_top
  import lp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic top_pwr_sw,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic op1
);

  localparam logic [1:0] UP_LAST = 2'(PWR_UP_CYCLES - 1);

  pwr_state_t state;
  logic [1:0] up_cnt;
  logic       sw_en;
  logic       iso;
  logic       restore;
  logic       ret_q;
  logic       core_q;

  // Power-controller FSM. The decoded controls are registered alongside the
  // state so op1 has no combinational path from the request or data inputs.
  // The request is only looked at in OFF and ON, so a change during a
  // transition is picked up as soon as the sequence settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      up_cnt  <= 2'd0;
      sw_en   <= 1'b0;
      iso     <= 1'b1;
      restore <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (top_pwr_sw) begin
            state  <= ST_UP;
            up_cnt <= 2'd0;
            sw_en  <= 1'b1;
          end
        end
        ST_UP: begin
          if (up_cnt == UP_LAST) begin
            state   <= ST_RESTORE;
            up_cnt  <= 2'd0;
            restore <= 1'b1;
          end else begin
            up_cnt <= up_cnt + 2'd1;
          end
        end
        ST_RESTORE: begin
          state   <= ST_ON;
          restore <= 1'b0;
          iso     <= 1'b0;
        end
        ST_ON: begin
          if (!top_pwr_sw) begin
            state <= ST_SAVE;
            iso   <= 1'b1;
          end
        end
        ST_SAVE: begin
          state <= ST_DOWN;
          sw_en <= 1'b0;
        end
        ST_DOWN: begin
          state <= ST_OFF;
        end
        default: begin
          state   <= ST_OFF;
          up_cnt  <= 2'd0;
          sw_en   <= 1'b0;
          iso     <= 1'b1;
          restore <= 1'b0;
        end
      endcase
    end
  end

  // Retention register in the always-on domain. In SAVE core_q still holds
  // the value loaded on the last ON edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= 1'b0;
    end else if (state == ST_SAVE) begin
      ret_q <= core_q;
    end
  end

  lp_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_en   (sw_en),
    .restore (restore),
    .ret_d   (ret_q),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .core_q  (core_q)
  );

  // Isolation cell: clamp op1 whenever the core output may be invalid.
  assign op1 = iso ? ISO_CLAMP : core_q;

endmodule : lp_design_top

// File: tb/tb_lp_design_top.sv
// tb_lp_design_top
// Self-checking bench for lp_design_top: directed power sequences followed
// by randomized request/data traffic, compared each cycle against an
// edge-count based reference model of the power protocol.
module tb_lp_design_top;

  logic clk;
  logic rst_n;
  logic top_pwr_sw;
  logic in1;
  logic in2;
  logic in3;
  logic op1;

  int total;
  int bad;

  // Reference model: edges are numbered; a power-up started at edge s shows
  // the retained value after edge s+3 and live data from edge s+4 on.
  int edge_n;
  bit m_running;
  int m_start;
  int m_avail;
  bit m_core;
  bit m_ret;
  bit m_out;

  lp_design_top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .top_pwr_sw (top_pwr_sw),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .op1        (op1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: edge=%0d got=%0b expected=%0b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_running = 1'b0;
    m_ret     = 1'b0;
    m_core    = 1'b0;
    m_out     = 1'b0;
    m_avail   = 0;
  endtask

  // Advance the model by one clock edge with the sampled request and data.
  task automatic modelStep(input bit pwr, input bit a, input bit b, input bit c);
    bit f;
    f = (a & b) ^ c;
    edge_n++;
    if (!m_running) begin
      m_out = 1'b0;
      if (edge_n >= m_avail && pwr) begin
        m_running = 1'b1;
        m_start   = edge_n;
      end
    end else if (edge_n < m_start + 3) begin
      m_out = 1'b0;
    end else if (edge_n == m_start + 3) begin
      m_core = m_ret;
      m_out  = m_core;
    end else begin
      m_core = f;
      if (pwr) begin
        m_out = m_core;
      end else begin
        m_out     = 1'b0;
        m_ret     = m_core;
        m_running = 1'b0;
        m_avail   = edge_n + 3;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare op1 just after the edge.
  task automatic applyStimulus(input bit pwr, input bit a, input bit b, input bit c);
    top_pwr_sw = pwr;
    in1        = a;
    in2        = b;
    in3        = c;
    @(posedge clk);
    modelStep(pwr, a, b, c);
    #1;
    checkOutput("op1", op1, m_out);
  endtask

  task automatic applyPattern(input bit pwr, input logic [2:0] abc, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(pwr, abc[2], abc[1], abc[0]);
    end
  endtask

  // Asynchronous reset: op1 must drop at once, without waiting for a clock.
  task automatic doReset();
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("rst_op1", op1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_op1", op1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    edge_n     = 0;
    m_start    = 0;
    rst_n      = 1'b0;
    top_pwr_sw = 1'b0;
    in1        = 1'b0;
    in2        = 1'b0;
    in3        = 1'b0;
    resetModel();
    #2;
    checkOutput("por_op1", op1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stays OFF with the request low, whatever the data.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Power up with 110: 0 through edge 3 (retained 0), then f = 1.
    applyPattern(1'b1, 3'b110, 5);
    applyPattern(1'b1, 3'b111, 1);
    applyPattern(1'b1, 3'b000, 1);
    applyPattern(1'b1, 3'b101, 1);

    // Power down holding 101 (retains 1), data changes while off.
    applyPattern(1'b0, 3'b101, 1);
    applyPattern(1'b0, 3'b010, 1);
    applyPattern(1'b0, 3'b111, 1);
    applyPattern(1'b0, 3'b110, 1);

    // Re-raise with 001: retained 1, then f = 1; drop while f = 1.
    applyPattern(1'b1, 3'b001, 6);
    applyPattern(1'b0, 3'b001, 3);

    // Re-raise with 010: retained 1, then f = 0.
    applyPattern(1'b1, 3'b010, 6);

    // Retain a 1 again, start powering up, then reset during UP.
    applyPattern(1'b1, 3'b001, 1);
    applyPattern(1'b0, 3'b001, 3);
    applyPattern(1'b1, 3'b110, 1);
    doReset();

    // After reset: nothing happens until the request is sampled high, and
    // the first ON cycle shows the cleared retention value.
    applyPattern(1'b0, 3'b110, 3);
    applyPattern(1'b1, 3'b110, 6);

    // Randomized traffic: slowly toggling request, random data.
    for (int i = 0; i < 400; i++) begin
      bit pwr;
      pwr = top_pwr_sw;
      if ($urandom_range(0, 7) == 0) begin
        pwr = ~pwr;
      end
      if (i == 250) begin
        doReset();
      end
      applyStimulus(pwr, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lp_design_top

// File: doc/lp_design_top.md
# lp_design_top

Low-power demonstration top with two power domains: an always-on domain (supply VDD_1d0) holding a power-controller FSM, retention register and output isolation, and a switchable core domain (supply VDD_0d8, ground VSS). The core computes a registered 3-input logic function. A software-visible power request, `top_pwr_sw`, sequences the core through save, isolate, power-down and power-up/restore. Implements DUT `design_top`; it is the root of the low-power basics test environment.

## Interface
- No parameters. Internal constants: `PWR_UP_CYCLES` = 2.
- One clock; reset is asynchronous and active-low.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `top_pwr_sw` input 1: core power request, 1 = on, 0 = off. Sampled on `clk`; already synchronous.
- `in1`, `in2`, `in3` input 1 each: data inputs to the core.
- `op1` output 1: isolated, registered core result.

## Operation
- Core function: `f = (in1 & in2) ^ in3`. Core register `core_q` loads `f` every clock while the FSM is in ON.
- The always-on retention register `ret_q` loads `core_q` in SAVE. `core_q` loads `ret_q` in RESTORE.
- `op1 = iso ? 1'b0 : core_q`. The clamp value is 0.
- FSM states and decoded controls (`sw_en` = core switch enable, `iso` = isolation):
  - OFF: `sw_en`=0, `iso`=1. Goes to UP when `top_pwr_sw`=1.
  - UP: `sw_en`=1, `iso`=1. Stays `PWR_UP_CYCLES` cycles, then goes to RESTORE.
  - RESTORE: `sw_en`=1, `iso`=1. Goes to ON after 1 cycle.
  - ON: `sw_en`=1, `iso`=0. Goes to SAVE when `top_pwr_sw`=0.
  - SAVE: `sw_en`=1, `iso`=1. Goes to DOWN after 1 cycle.
  - DOWN: `sw_en`=0, `iso`=1. Goes to OFF after 1 cycle.
- A request change during UP, RESTORE, SAVE or DOWN is not acted on until the sequence reaches ON or OFF. Once there, the level is re-evaluated, so no request level is lost.
- While `sw_en`=0, the RTL forces `core_q` to 0. Under UPF simulation the VDD_0d8 shutoff corrupts it instead.
- Turning off the VDD_0d8 supply externally while in ON is outside the control protocol. `op1` is then undefined (corrupt) until a full power cycle.
- Reset values: state=OFF, `core_q`=0, `ret_q`=0, UP counter=0, so `op1`=0.

## Timing
- Edge numbering: the edge that samples `top_pwr_sw`=1 in OFF is edge 0.
  - State is UP after edge 0.
  - State is RESTORE after edge 2.
  - State is ON after edge 3. From then `iso`=0 and `op1 = ret_q`.
  - After edge 4, `op1 = f` of the inputs sampled at edge 4.
- In ON, latency from inputs to `op1` is 1 clock.
- Power-down: when edge k samples `top_pwr_sw`=0 in ON, `op1` clamps to 0 right after edge k (state SAVE).
  - `ret_q` captures `core_q` at edge k+1.
  - State is OFF after edge k+2.
- `iso`, `sw_en` and `op1` decode from registered state plus `core_q`. They carry no combinational path from `in*` or `top_pwr_sw`.
- Reset asserted mid-sequence: immediately OFF, `op1`=0, `ret_q` cleared.

## Structure
- Package `lp_pkg`:
  - state enum `pwr_state_t` (OFF, UP, RESTORE, ON, SAVE, DOWN)
  - constant `PWR_UP_CYCLES`
  - clamp value constant `ISO_CLAMP` = 0
- Sub-module `lp_core`, placed in the switchable domain: `clk`, `rst_n`, `sw_en`, `restore`, `ret_d`, `in1..in3`, `core_q`.
- Top holds the FSM, `ret_q` and the isolation AND gate, all in the always-on domain.
- The UPF file declares:
  - supplies `/dut_top/VDD_1d0` (1.0 V, always-on), `/dut_top/VDD_0d8` (0.8 V, core) and `/dut_top/VSS`
  - a power switch on `sw_en`
  - an isolation strategy on `op1` (clamp 0, control `iso`)
  - a retention strategy on `core_q`

## Test plan
- Reset with all supplies on, `top_pwr_sw`=0, inputs 000 → `op1`=0; state stays OFF for 20 cycles regardless of inputs.
- Raise `top_pwr_sw`=1 with inputs 110 → `op1`=0 through edge 3, then `op1`=1 from edge 4 onward (`f`=1).
- In ON, apply inputs 111, 000, 101 on successive cycles → `op1` = 0, 0, 1, each one clock later.
- In ON with inputs 101 (`core_q`=1), drop `top_pwr_sw` → `op1`=0 the next cycle. Apply inputs 010, 111, 110 while off → `op1` stays 0.
- Re-raise `top_pwr_sw` with inputs 001 → first ON cycle `op1`=1 (retained value), then `op1`=1 (`f`(0,0,1)=1). Repeat with inputs 010 → `op1`=1 then 0.
- Assert `rst_n`=0 during UP → `op1`=0 and state OFF immediately. After release, the sequence restarts only when `top_pwr_sw`=1 is sampled, and restores `ret_q`=0.
